wallace_cpa_stage: RTL and testbench

//  Final carry-propagate adder stage of the 8x8 Wallace-tree multiplier.
//  - Consumes the two reduced rows (sum row, carry row) left after the FA/HA reduction tree.
//  - Adds the rows into the 16-bit product and presents it downstream.
//  - Elastic valid/ready pipeline: 1 register stage by default, 2 stages when split.
//  - Sits between the combinational reduction tree and the multiplier result interface.

---
 rtl/mul8_pkg.sv | 7 +
 rtl/rca_chain.sv | 18 +
 rtl/wallace_cpa_stage.sv | 103 ++++++++++
 tb/tb_wallace_cpa_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// mul8_pkg: shared widths and row types for the 8x8 Wallace-tree multiplier
package mul8_pkg;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   typedef logic [PROD_W-1:0] prod_t;
   typedef struct packed {prod_t sum; prod_t carry;} rows_t;
endpackage

// File: rtl/rca_chain.sv
// rca_chain: combinational N-bit ripple-carry adder built from full-adder cells
module rca_chain #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   output logic [N-1:0] s_o,
   output logic         cout_o
);
   logic [N:0] c;
   assign c[0] = cin_i;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end
   assign cout_o = c[N];
endmodule

// File: rtl/wallace_cpa_stage.sv
// wallace_cpa_stage: final CPA of the Wallace multiplier; WCPA_TWO_STAGE_EN splits it into lo/hi stages
module wallace_cpa_stage
   import mul8_pkg::*;
#(
   parameter int W    = PROD_W,
   parameter int LO_W = W / 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_sum_i,
   input  logic [W-1:0] in_carry_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_prod_o,
   output logic         out_cout_o
);
   if (W % 2 != 0 || W < 4 || LO_W < 1 || LO_W >= W) begin : g_bad_cfg
      $error("wallace_cpa_stage: illegal W/LO_W");
   end
   logic         out_v_q, cout_q, cout_d;
   logic [W-1:0] prod_q, prod_d;
   assign out_valid_o = out_v_q;
   assign out_prod_o  = prod_q;
   assign out_cout_o  = cout_q;
`ifdef WCPA_TWO_STAGE_EN
   localparam int HI_W = W - LO_W;
   logic            va_q, clo_q, clo_d, ready_b;
   logic [LO_W-1:0] lo_q, lo_d;
   logic [HI_W-1:0] sh_q, ch_q, hi_d;
   rca_chain #(.N(LO_W)) u_lo (
      .a_i   (in_sum_i[LO_W-1:0]),
      .b_i   (in_carry_i[LO_W-1:0]),
      .cin_i (1'b0),
      .s_o   (lo_d),
      .cout_o(clo_d)
   );
   rca_chain #(.N(HI_W)) u_hi (
      .a_i   (sh_q),
      .b_i   (ch_q),
      .cin_i (clo_q),
      .s_o   (hi_d),
      .cout_o(cout_d)
   );
   assign prod_d     = {hi_d, lo_q};
   assign ready_b    = !out_v_q || out_ready_i;
   assign in_ready_o = !va_q || ready_b;
   // stage A holds the low sum and its carry plus the raw high halves; stage B finishes the add
   always_ff @(posedge clk) begin
      if (rst) begin
         va_q    <= 1'b0;
         clo_q   <= 1'b0;
         lo_q    <= '0;
         sh_q    <= '0;
         ch_q    <= '0;
         out_v_q <= 1'b0;
         prod_q  <= '0;
         cout_q  <= 1'b0;
      end else begin
         if (in_ready_o) begin
            va_q <= in_valid_i;
            if (in_valid_i) begin
               lo_q  <= lo_d;
               clo_q <= clo_d;
               sh_q  <= in_sum_i[W-1:LO_W];
               ch_q  <= in_carry_i[W-1:LO_W];
            end
         end
         if (ready_b) begin
            out_v_q <= va_q;
            if (va_q) begin
               prod_q <= prod_d;
               cout_q <= cout_d;
            end
         end
      end
   end
`else
   rca_chain #(.N(W)) u_full (
      .a_i   (in_sum_i),
      .b_i   (in_carry_i),
      .cin_i (1'b0),
      .s_o   (prod_d),
      .cout_o(cout_d)
   );
   assign in_ready_o = !out_v_q || out_ready_i;
   // single result register, refilled whenever it is empty or being drained
   always_ff @(posedge clk) begin
      if (rst) begin
         out_v_q <= 1'b0;
         prod_q  <= '0;
         cout_q  <= 1'b0;
      end else if (in_ready_o) begin
         out_v_q <= in_valid_i;
         if (in_valid_i) begin
            prod_q <= prod_d;
            cout_q <= cout_d;
         end
      end
   end
`endif
endmodule

// File: tb/tb_wallace_cpa_stage.sv
// tb_wallace_cpa_stage: self-checking bench with a queue-based reference model of the CPA stage
module tb_wallace_cpa_stage;
`ifdef WCPA_TWO_STAGE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_cout;
   logic [15:0] in_sum = '0, in_carry = '0, out_prod;
   logic [16:0] exp_q[$];
   logic [16:0] gold;
   bit          use_gold = 0;
   bit          took, acc;
   int          n_cmp = 0, n_bad = 0, n_take = 0;

   always #5 clk = ~clk;

   wallace_cpa_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_sum_i   (in_sum),
      .in_carry_i (in_carry),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_prod_o (out_prod),
      .out_cout_o (out_cout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // called at a falling edge with inputs already driven; models the transfers of the coming rising edge
   task automatic tick();
      logic [16:0] e;
      #1;
      took = 0;
      acc  = 0;
      if (!rst) begin
         if (out_valid && out_ready) begin
            took = 1;
            n_take++;
            chk("result_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_prod", 32'(out_prod), 32'(e[15:0]));
               chk("out_cout", 32'(out_cout), 32'(e[16]));
            end
         end
         if (in_valid && in_ready) begin
            acc = 1;
            exp_q.push_back(use_gold ? gold : 17'(in_sum) + 17'(in_carry));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lat_test(input string tag, input logic [15:0] s, input logic [15:0] c);
      int n;
      in_valid = 1;
      in_sum   = s;
      in_carry = c;
      tick();
      chk({tag, "_accept"}, 32'(acc), 1);
      in_valid = 0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!took && n < 10);
      chk({tag, "_latency"}, n, LAT);
   endtask

   initial begin
      int k, t0, n_acc, n;
      logic [7:0]  a, b;
      logic [15:0] p, x;
      @(negedge clk);
      tick();
      tick();
      rst = 0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_prod", 32'(out_prod), 0);
      chk("rst_out_cout", 32'(out_cout), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      lat_test("fe00", 16'hFE00, 16'h0001);
      chk("fe00_value", 32'(out_prod), 32'hFE01);
      lat_test("xhalf", 16'h00FF, 16'h0001);
      chk("xhalf_value", 32'(out_prod), 32'h0100);
      lat_test("wrap", 16'hFFFF, 16'h0001);
      chk("wrap_value", 32'(out_prod), 0);
      chk("wrap_cout", 32'(out_cout), 1);
      out_ready = 0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1;
         in_sum   = 16'(k + 1);
         in_carry = 16'(k + 1);
         tick();
         if (acc) k++;
      end
      chk("bp_accepts", k, LAT);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_no_output", 32'(n_take), 3);
      out_ready = 1;
      t0 = n_take;
      n = 0;
      while ((k < 3 || exp_q.size() != 0) && n < 20) begin
         in_valid = (k < 3);
         in_sum   = 16'(k + 1);
         in_carry = 16'(k + 1);
         tick();
         if (acc) k++;
         n++;
      end
      in_valid = 0;
      chk("bp_drained", 32'(exp_q.size()), 0);
      chk("bp_takes", n_take - t0, 3);
      use_gold = 1;
      t0 = n_take;
      n_acc = 0;
      in_valid = 1;
      for (int i = 0; i < 256; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         p = 16'(a) * 16'(b);
         x = 16'($urandom_range(32'(p), 0));
         gold = 17'(p);
         in_sum = p - x;
         in_carry = x;
         tick();
         if (acc) n_acc++;
      end
      in_valid = 0;
      chk("stream_accepts", n_acc, 256);
      chk("stream_takes", n_take - t0, 256 - LAT);
      n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         tick();
         n++;
      end
      chk("stream_drained", 32'(exp_q.size()), 0);
      use_gold = 0;
      out_ready = 0;
      in_valid = 1;
      in_sum = 16'h0011;
      in_carry = 16'h0022;
      tick();
      in_sum = 16'h0033;
      in_carry = 16'h0044;
      tick();
      chk("mid_out_valid_before", 32'(out_valid), 1);
      rst = 1;
      in_sum = 16'h0555;
      in_carry = 16'h0666;
      tick();
      rst = 0;
      in_valid = 0;
      exp_q.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_prod", 32'(out_prod), 0);
      out_ready = 1;
      tick();
      chk("mid_rst_idle", 32'(took), 0);
      lat_test("post_rst", 16'h1234, 16'h0101);
      chk("post_rst_value", 32'(out_prod), 32'h1335);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
